// File: rtl/stream_downsize.sv
// rtl/stream_downsize.sv - wide-to-narrow stream converter, emits kept lanes one per beat, lane 0 first
module stream_downsize #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IDX_W = $clog2(T_DATA_RATIO);
    localparam logic [T_DATA_RATIO-1:0] LSB_ONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state;
    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_q;
    logic                    last_q;

    logic [IDX_W-1:0]        idx;
    logic [T_DATA_RATIO-1:0] rem_next;
    logic                    single;
    logic                    beat;
    logic                    final_beat;
    logic                    accept;

    // Lowest set bit of the remaining mask picks the lane; scanning high-to-low lets the lowest win.
    always_comb begin
        idx = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
    end

    assign rem_next   = rem_q & (rem_q - LSB_ONE);
    assign single     = (rem_q != '0) && (rem_next == '0);
    assign m_valid_o  = (state == SEND);
    assign m_data_o   = m_valid_o ? data_q[idx] : '0;
    assign m_last_o   = m_valid_o & last_q & single;
    assign beat       = m_valid_o & m_ready_i;
    assign final_beat = beat & single;
    // Ready on the final beat lets the next word load in the same edge, so words stream without a bubble.
    assign s_ready_o  = (state == IDLE) | final_beat;
    assign accept     = s_valid_i & s_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem_q  <= '0;
            last_q <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    data_q[i] <= s_data_i[i];
                end
                rem_q  <= s_keep_i;
                last_q <= s_last_i;
                state  <= (s_keep_i != '0) ? SEND : IDLE;
            end else if (beat) begin
                rem_q <= rem_next;
                if (single) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// tb/tb_stream_downsize.sv - directed self-checking bench for stream_downsize
module tb_stream_downsize;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data [4];
    logic [3:0] s_keep;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    int errors;
    int checks;

    stream_downsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_keep_i  (s_keep),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_word(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input logic [3:0] keep, input logic last);
        s_data[0] = d0;
        s_data[1] = d1;
        s_data[2] = d2;
        s_data[3] = d3;
        s_keep    = keep;
        s_last    = last;
        s_valid   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_keep  = 4'h0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) s_data[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", m_last); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_full_word();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hA3;
        @(posedge clk); #1;
        load_word(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111, 1'b1);
        m_ready = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL full_valid beat %0d: got %b expected 1", k, m_valid); end
            checks++; if (m_data !== exp_d[k]) begin errors++; $display("FAIL full_data beat %0d: got %h expected %h", k, m_data, exp_d[k]); end
            checks++; if (m_last !== (k == 3)) begin errors++; $display("FAIL full_last beat %0d: got %b expected %b", k, m_last, (k == 3)); end
        end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_after_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_partial_word();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'hD0; exp_d[1] = 8'hD1; exp_d[2] = 8'hD2;
        @(posedge clk); #1;
        load_word(8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'b0111, 1'b1);
        @(posedge clk); #1 s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (m_data !== exp_d[k]) begin errors++; $display("FAIL partial_data beat %0d: got %h expected %h", k, m_data, exp_d[k]); end
            checks++; if (m_last !== (k == 2)) begin errors++; $display("FAIL partial_last beat %0d: got %b expected %b", k, m_last, (k == 2)); end
            checks++; if (s_ready !== (k == 2)) begin errors++; $display("FAIL partial_ready beat %0d: got %b expected %b", k, s_ready, (k == 2)); end
        end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL partial_after_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8];
        exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12; exp_d[3] = 8'h13;
        exp_d[4] = 8'h20; exp_d[5] = 8'h21; exp_d[6] = 8'h22; exp_d[7] = 8'h23;
        @(posedge clk); #1;
        load_word(8'h10, 8'h11, 8'h12, 8'h13, 4'b1111, 1'b0);
        @(posedge clk); #1;
        load_word(8'h20, 8'h21, 8'h22, 8'h23, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d: got %b expected 1", k, m_valid); end
            checks++; if (m_data !== exp_d[k]) begin errors++; $display("FAIL b2b_data beat %0d: got %h expected %h", k, m_data, exp_d[k]); end
            checks++; if (m_last !== (k == 7)) begin errors++; $display("FAIL b2b_last beat %0d: got %b expected %b", k, m_last, (k == 7)); end
            if (k < 4) begin
                checks++; if (s_ready !== (k == 3)) begin errors++; $display("FAIL b2b_ready beat %0d: got %b expected %b", k, s_ready, (k == 3)); end
            end
            if (k == 3) begin
                @(posedge clk); #1 s_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_sparse_stall();
        @(posedge clk); #1;
        load_word(8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'b1010, 1'b1);
        m_ready = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_data !== 8'hE1) begin errors++; $display("FAIL sparse_d1: got %h expected e1", m_data); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL sparse_d1_last: got %b expected 0", m_last); end
        @(posedge clk); #1 m_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_data !== 8'hE3) begin errors++; $display("FAIL sparse_d3: got %h expected e3", m_data); end
        checks++; if (m_last !== 1'b1) begin errors++; $display("FAIL sparse_d3_last: got %b expected 1", m_last); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL sparse_stall_ready: got %b expected 0", s_ready); end
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL sparse_hold_valid: got %b expected 1", m_valid); end
        checks++; if (m_data !== 8'hE3) begin errors++; $display("FAIL sparse_hold_data: got %h expected e3", m_data); end
        checks++; if (m_last !== 1'b1) begin errors++; $display("FAIL sparse_hold_last: got %b expected 1", m_last); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL sparse_final_ready: got %b expected 1", s_ready); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sparse_after_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_empty_keep();
        @(posedge clk); #1;
        load_word(8'h55, 8'h66, 8'h77, 8'h88, 4'b0000, 1'b0);
        @(posedge clk); #1;
        load_word(8'hF0, 8'hF1, 8'hF2, 8'hF3, 4'b0001, 1'b1);
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b expected 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b expected 1", s_ready); end
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL empty_next_valid: got %b expected 1", m_valid); end
        checks++; if (m_data !== 8'hF0) begin errors++; $display("FAIL empty_next_data: got %h expected f0", m_data); end
        checks++; if (m_last !== 1'b1) begin errors++; $display("FAIL empty_next_last: got %b expected 1", m_last); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_after_valid: got %b expected 0", m_valid); end
    endtask

    task automatic test_reset_mid_word();
        @(posedge clk); #1;
        load_word(8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b1111, 1'b1);
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        checks++; if (m_data !== 8'hC0) begin errors++; $display("FAIL rst_mid_d0: got %h expected c0", m_data); end
        @(negedge clk);
        checks++; if (m_data !== 8'hC1) begin errors++; $display("FAIL rst_mid_d1: got %h expected c1", m_data); end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async_valid: got %b expected 0", m_valid); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after_valid cycle %0d: got %b expected 0", k, m_valid); end
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after_ready cycle %0d: got %b expected 1", k, s_ready); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_full_word();
        test_partial_word();
        test_back_to_back();
        test_sparse_stall();
        test_empty_keep();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
